// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the SD4 MAC pipeline: issues 3x3 windows into a fixed-latency
// MAC, tracks in-flight windows and buffers results in a credit-protected FIFO.
module mac_seq_ctrl #(
  parameter int LAT       = 5,
  parameter int OUT_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [CNT_W-1:0] cfg_num_win,
  input  logic [4:0]       cfg_exp_bias,
  output logic             busy,
  output logic             done,
  input  logic             win_valid,
  output logic             win_ready,
  input  logic [71:0]      win_image,
  input  logic [35:0]      win_weight,
  output logic [71:0]      mac_image,
  output logic [35:0]      mac_weight,
  output logic [4:0]       mac_exp_bias,
  input  logic [15:0]      mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [15:0]      res_data,
  output logic             res_last,
  output logic [1:0]       o_dbg_state
);

  localparam int PTW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CTW = $clog2(OUT_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Handshakes: a window transfers when win_valid & win_ready (fire), a result
  // leaves when res_valid & res_ready (pop); both sampled on the rising edge.
  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_accept;
  logic [CNT_W-1:0] r_num;
  logic [4:0]       r_bias;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_popped;
  logic [LAT-1:0]   r_vld_sr;
  logic [15:0]      r_mem [OUT_DEPTH];
  logic [PTW-1:0]   r_wr_ptr;
  logic [PTW-1:0]   r_rd_ptr;
  logic [CTW-1:0]   r_count;

  logic             w_can_issue;
  logic             w_fire;
  logic             w_push;
  logic             w_pop;
  logic             w_res_valid;
  logic [OCW-1:0]   w_inflight;
  logic [OCW-1:0]   w_outstanding;
  logic [CNT_W-1:0] w_issued_inc;
  logic [CNT_W-1:0] w_num_m1;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + OCW'(r_vld_sr[i]);
    end
  end

  // Credit covers both queued and in-flight results, so a push can never overflow.
  assign w_outstanding = OCW'(r_count) + w_inflight;
  assign w_can_issue   = (r_state == S_RUN) && (r_issued < r_num) &&
                         (w_outstanding < OCW'(OUT_DEPTH));
  assign w_fire        = win_valid & w_can_issue;
  assign w_push        = r_vld_sr[LAT-1];
  assign w_res_valid   = (r_count != '0);
  assign w_pop         = w_res_valid & res_ready;
  assign w_issued_inc  = r_issued + CNT_W'(1);
  assign w_num_m1      = r_num - CNT_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          w_accept = 1'b1;
          if (cfg_num_win != '0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (w_fire && (w_issued_inc == r_num)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && (r_popped == w_num_m1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_num    <= '0;
      r_bias   <= '0;
      r_issued <= '0;
      r_popped <= '0;
      r_vld_sr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_done   <= w_done_nxt;
      r_vld_sr <= {r_vld_sr[LAT-2:0], w_fire};
      if (w_accept) begin
        r_num    <= cfg_num_win;
        r_bias   <= cfg_exp_bias;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_fire) begin
          r_issued <= w_issued_inc;
        end
        if (w_pop && (r_state != S_IDLE)) begin
          r_popped <= r_popped + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTW'(OUT_DEPTH - 1)) ? '0 : r_wr_ptr + PTW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTW'(OUT_DEPTH - 1)) ? '0 : r_rd_ptr + PTW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CTW'(1);
        2'b01:   r_count <= r_count - CTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= mac_out;
    end
  end

  assign busy         = (r_state != S_IDLE) | r_done;
  assign done         = r_done;
  assign win_ready    = w_can_issue;
  assign mac_image    = w_fire ? win_image : '0;
  assign mac_weight   = w_fire ? win_weight : '0;
  assign mac_exp_bias = r_bias;
  assign res_valid    = w_res_valid;
  assign res_data     = w_res_valid ? r_mem[r_rd_ptr] : '0;
  assign res_last     = w_res_valid && (r_state != S_IDLE) && (r_popped == w_num_m1);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: behavioural MAC pipeline, golden result
// queue in fire order, and per-scenario tasks driving randomized jobs.
module tb_mac_seq_ctrl;

  localparam int LAT       = 5;
  localparam int OUT_DEPTH = 8;
  localparam int CNT_W     = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cfg_start;
  logic [CNT_W-1:0] cfg_num_win;
  logic [4:0]       cfg_exp_bias;
  logic             busy;
  logic             done;
  logic             win_valid;
  logic             win_ready;
  logic [71:0]      win_image;
  logic [35:0]      win_weight;
  logic [71:0]      mac_image;
  logic [35:0]      mac_weight;
  logic [4:0]       mac_exp_bias;
  logic [15:0]      mac_out;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic             res_last;
  logic [1:0]       o_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  int          m_num      = 0;
  int          m_popped   = 0;
  int          m_fires    = 0;
  int          m_results  = 0;
  int          done_cnt   = 0;
  logic [4:0]  m_bias     = '0;
  bit          stall_prev = 0;
  logic [15:0] prev_data;
  logic        prev_last;

  logic [15:0] pipe [LAT];

  mac_seq_ctrl #(.LAT(LAT), .OUT_DEPTH(OUT_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_num_win(cfg_num_win), .cfg_exp_bias(cfg_exp_bias),
    .busy(busy), .done(done),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_image(win_image), .win_weight(win_weight),
    .mac_image(mac_image), .mac_weight(mac_weight), .mac_exp_bias(mac_exp_bias),
    .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  // Golden MAC: unsigned pixels times signed 4-bit weights, plus the bias.
  function automatic logic [15:0] golden(input logic [71:0] img, input logic [35:0] wt,
                                         input logic [4:0] b);
    int acc;
    acc = int'(b);
    for (int i = 0; i < 9; i++) begin
      acc = acc + int'(img[i*8 +: 8]) * int'($signed(wt[i*4 +: 4]));
    end
    return 16'(acc);
  endfunction

  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= golden(mac_image, mac_weight, mac_exp_bias);
  end
  assign mac_out = pipe[LAT-1];

  // Scoreboard: fires enqueue golden results, pops must match them in order.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (win_valid && win_ready) begin
        n_checks++;
        if (mac_image !== win_image || mac_weight !== win_weight) begin
          n_fail++;
          $display("FAIL mac_pass: got %h/%h want %h/%h", mac_image, mac_weight, win_image, win_weight);
        end
        exp_q.push_back(golden(win_image, win_weight, m_bias));
        m_fires++;
      end else begin
        n_checks++;
        if (mac_image !== '0 || mac_weight !== '0) begin
          n_fail++;
          $display("FAIL mac_bubble: got %h/%h want 0/0", mac_image, mac_weight);
        end
      end
      if (stall_prev) begin
        n_checks++;
        if (res_valid !== 1'b1 || res_data !== prev_data || res_last !== prev_last) begin
          n_fail++;
          $display("FAIL res_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   res_valid, res_data, res_last, prev_data, prev_last);
        end
      end
      if (res_valid && res_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL res_extra: got result %h want none", res_data);
        end else begin
          logic [15:0] e;
          logic        el;
          e  = exp_q.pop_front();
          el = (m_popped == m_num - 1);
          if (res_data !== e) begin
            n_fail++;
            $display("FAIL res_data: got %h want %h (index %0d)", res_data, e, m_popped);
          end
          n_checks++;
          if (res_last !== el) begin
            n_fail++;
            $display("FAIL res_last: got %b want %b (index %0d)", res_last, el, m_popped);
          end
        end
        m_popped++;
        m_results++;
      end
      stall_prev = res_valid && !res_ready;
      prev_data  = res_data;
      prev_last  = res_last;
      if (done === 1'b1) done_cnt++;
    end else begin
      stall_prev = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_win();
    for (int i = 0; i < 9; i++) begin
      win_image[i*8 +: 8]  = 8'($urandom_range(0, 255));
      win_weight[i*4 +: 4] = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic begin_job(input int num, input logic [4:0] bias);
    m_num        = num;
    m_popped     = 0;
    m_bias       = bias;
    cfg_start    = 1'b1;
    cfg_num_win  = CNT_W'(num);
    cfg_exp_bias = bias;
  endtask

  task automatic drive_until_done(input int d0, input int vpct, input int rpct,
                                  input int budget, output bit seen);
    seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      win_valid = ($urandom_range(0, 99) < vpct);
      res_ready = ($urandom_range(0, 99) < rpct);
      rand_win();
      step();
      cfg_start = 1'b0;
      if (done_cnt != d0) seen = 1;
    end
    win_valid = 1'b0;
    res_ready = 1'b1;
  endtask

  task automatic run_job(input int num, input logic [4:0] bias, input int vpct,
                         input int rpct, input string name);
    int d0, f0, r0;
    bit seen;
    d0 = done_cnt; f0 = m_fires; r0 = m_results;
    begin_job(num, bias);
    drive_until_done(d0, vpct, rpct, 40 * num + 60, seen);
    step(); step();
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: no done within budget", name);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d want 1", name, done_cnt - d0);
    end
    n_checks++;
    if (m_fires - f0 != num || m_results - r0 != num) begin
      n_fail++;
      $display("FAIL %s_counts: got fires=%0d results=%0d want %0d", name,
               m_fires - f0, m_results - r0, num);
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || mac_exp_bias !== bias) begin
      n_fail++;
      $display("FAIL %s_end: got q=%0d busy=%b bias=%0d want q=0 busy=0 bias=%0d", name,
               exp_q.size(), busy, mac_exp_bias, bias);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cfg_start = 1'b0; cfg_num_win = '0; cfg_exp_bias = '0;
    win_valid = 1'b1; res_ready = 1'b1;
    rand_win();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, win_ready, res_valid, res_last} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {busy, done, win_ready, res_valid, res_last});
    end
    n_checks++;
    if (mac_image !== '0 || mac_weight !== '0) begin
      n_fail++;
      $display("FAIL reset_mac: got %h/%h want 0/0", mac_image, mac_weight);
    end
    n_checks++;
    if (mac_exp_bias !== '0 || res_data !== '0 || o_dbg_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_data: got bias=%0d data=%h st=%0d want 0", mac_exp_bias, res_data, o_dbg_state);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    win_valid = 1'b0;
    step();
  endtask

  task automatic test_basic_timing();
    logic e_wr, e_rv, e_last, e_done, e_busy;
    begin_job(4, 5'd7);
    win_valid = 1'b1; res_ready = 1'b1;
    rand_win();
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      e_wr   = (c >= 1 && c <= 4);
      e_rv   = (c >= 7 && c <= 10);
      e_last = (c == 10);
      e_done = (c == 11);
      e_busy = (c >= 1 && c <= 11);
      n_checks++;
      if (win_ready !== e_wr) begin
        n_fail++;
        $display("FAIL basic_win_ready c%0d: got %b want %b", c, win_ready, e_wr);
      end
      n_checks++;
      if (res_valid !== e_rv || res_last !== e_last) begin
        n_fail++;
        $display("FAIL basic_res c%0d: got v=%b l=%b want v=%b l=%b", c, res_valid, res_last, e_rv, e_last);
      end
      n_checks++;
      if (done !== e_done || busy !== e_busy) begin
        n_fail++;
        $display("FAIL basic_done_busy c%0d: got d=%b b=%b want d=%b b=%b", c, done, busy, e_done, e_busy);
      end
      @(posedge clk); #1;
      cfg_start = 1'b0;
      rand_win();
    end
    win_valid = 1'b0;
    n_checks++;
    if (m_popped != 4 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL basic_total: got popped=%0d q=%0d want 4/0", m_popped, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int f0, d0;
    bit seen;
    f0 = m_fires; d0 = done_cnt;
    begin_job(20, 5'd19);
    win_valid = 1'b1; res_ready = 1'b0;
    for (int c = 0; c < 25; c++) begin
      rand_win();
      step();
      cfg_start = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (m_fires - f0 != OUT_DEPTH || win_ready !== 1'b0 || res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_credit: got fires=%0d ready=%b rv=%b want %0d/0/1",
               m_fires - f0, win_ready, res_valid, OUT_DEPTH);
    end
    @(posedge clk); #1;
    drive_until_done(d0, 100, 70, 400, seen);
    step();
    n_checks++;
    if (!seen || m_fires - f0 != 20 || m_popped != 20 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got done=%b fires=%0d popped=%0d q=%0d want 1/20/20/0",
               seen, m_fires - f0, m_popped, exp_q.size());
    end
  endtask

  task automatic test_zero_job();
    int f0;
    f0 = m_fires;
    begin_job(0, 5'd3);
    win_valid = 1'b1; res_ready = 1'b1;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (done !== (c == 1) || busy !== (c == 1)) begin
        n_fail++;
        $display("FAIL zero_done c%0d: got d=%b b=%b want %b", c, done, busy, (c == 1));
      end
      n_checks++;
      if (win_ready !== 1'b0 || res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_idle c%0d: got wr=%b rv=%b want 0/0", c, win_ready, res_valid);
      end
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    win_valid = 1'b0;
    n_checks++;
    if (m_fires != f0) begin
      n_fail++;
      $display("FAIL zero_fires: got %0d want 0", m_fires - f0);
    end
  endtask

  task automatic test_bubbles();
    int d0;
    bit seen;
    d0 = done_cnt;
    begin_job(3, 5'd12);
    win_valid = 1'b0; res_ready = 1'b1;
    rand_win();
    step();
    cfg_start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      win_valid = (c % 2 == 1);
      rand_win();
      step();
    end
    drive_until_done(d0, 0, 100, 40, seen);
    step();
    n_checks++;
    if (!seen || m_popped != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bubble_total: got done=%b popped=%0d q=%0d want 1/3/0", seen, m_popped, exp_q.size());
    end
  endtask

  task automatic test_ignore_start();
    int f0, d0;
    bit seen;
    f0 = m_fires; d0 = done_cnt;
    begin_job(6, 5'd9);
    win_valid = 1'b1; res_ready = 1'b1;
    rand_win();
    step(); cfg_start = 1'b0;
    rand_win(); step();
    rand_win(); step();
    cfg_start = 1'b1; cfg_num_win = CNT_W'(3); cfg_exp_bias = 5'd22;
    rand_win(); step();
    cfg_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mac_exp_bias !== 5'd9 || o_dbg_state !== 2'd1) begin
      n_fail++;
      $display("FAIL ignore_bias: got bias=%0d st=%0d want 9/1", mac_exp_bias, o_dbg_state);
    end
    @(posedge clk); #1;
    drive_until_done(d0, 80, 80, 200, seen);
    step(); step();
    n_checks++;
    if (!seen || m_fires - f0 != 6 || m_popped != 6 || done_cnt - d0 != 1 || mac_exp_bias !== 5'd9) begin
      n_fail++;
      $display("FAIL ignore_total: got done=%b fires=%0d popped=%0d dones=%0d bias=%0d want 1/6/6/1/9",
               seen, m_fires - f0, m_popped, done_cnt - d0, mac_exp_bias);
    end
  endtask

  task automatic test_reset_mid_job();
    int f0, d0;
    f0 = m_fires;
    begin_job(10, 5'd27);
    win_valid = 1'b1; res_ready = 1'b1;
    for (int k = 0; k < 30 && (m_fires - f0) < 3; k++) begin
      rand_win();
      step();
      cfg_start = 1'b0;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, win_ready, res_valid, res_last} !== 5'b0 || mac_image !== '0 ||
        mac_weight !== '0 || mac_exp_bias !== '0 || res_data !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got ctrl=%b bias=%0d data=%h want 0",
               {busy, done, win_ready, res_valid, res_last}, mac_exp_bias, res_data);
    end
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b1;
    win_valid = 1'b0;
    repeat (10) step();
    n_checks++;
    if (done_cnt != d0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_quiet: got dones=%0d rv=%b want 0/0", done_cnt - d0, res_valid);
    end
    run_job(2, 5'd4, 100, 100, "after_rst");
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = m_fires;
    begin_job(12, 5'd1);
    win_valid = 1'b1; res_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      rand_win();
      step();
      cfg_start = 1'b0;
    end
    n_checks++;
    if (m_fires - f0 != 12) begin
      n_fail++;
      $display("FAIL throughput: got %0d fires in 12 cycles want 12", m_fires - f0);
    end
    win_valid = 1'b0;
    repeat (20) step();
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 12), 5'($urandom_range(0, 31)),
              $urandom_range(50, 100), $urandom_range(30, 100), "b2b");
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_timing();
    repeat (3) step();
    test_backpressure();
    test_zero_job();
    test_bubbles();
    test_ignore_start();
    test_reset_mid_job();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Job-level sequencer for the 5-stage SD4 MAC pipeline. It takes a job descriptor (window count plus exponent bias), pulls 3×3 image/weight windows from an upstream valid/ready stream and issues them into the non-stallable MAC pipeline. It tracks in-flight windows with a latency-matched valid shift register and buffers results in a credit-protected output FIFO. It sits between the window-fetch logic and the MAC pipeline, and presents results as a valid/ready stream with a last-of-job marker.

## Interface
- LAT, 5: MAC pipeline latency in cycles, from issue to result on `mac_out`.
- OUT_DEPTH, 8: output FIFO depth. Must be ≥ LAT+1.
- CNT_W, 16: width of the window counters.

- clk  in  1  clock. All logic is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle job start. Sampled only in IDLE.
- cfg_num_win  in  CNT_W  number of windows in the job. Latched on accepted start.
- cfg_exp_bias  in  5  exponent bias for the job. Latched on accepted start.
- busy  out  1  high from accepted start until the `done` cycle, inclusive.
- done  out  1  one-cycle pulse at job completion.
- win_valid  in  1  upstream window valid.
- win_ready  out  1  sequencer can issue a window this cycle.
- win_image  in  72  nine 8-bit pixels.
- win_weight  in  36  nine 4-bit weights.
- mac_image  out  72  pipeline image input. Equals `win_image` on a fire cycle, otherwise 0.
- mac_weight  out  36  pipeline weight input. Equals `win_weight` on a fire cycle, otherwise 0.
- mac_exp_bias  out  5  latched job bias, held constant through issue and drain.
- mac_out  in  16  pipeline result.
- res_valid  out  1  FIFO non-empty.
- res_ready  in  1  downstream accepts a result.
- res_data  out  16  FIFO head.
- res_last  out  1  head is the final result of the job.

## Operation
- fire = win_valid & win_ready.
- pop = res_valid & res_ready.
- States:
  - IDLE: accepts `cfg_start`.
  - RUN: issues windows.
  - DRAIN: waits for results to leave.
- IDLE to RUN: on `cfg_start` with `cfg_num_win` ≠ 0. Latch `num`, `exp_bias`; clear `issued` and `popped`.
- IDLE with `cfg_start` and `cfg_num_win` = 0: `done` pulses the next cycle, `busy` is high for that one cycle, no window is issued.
- `cfg_start` outside IDLE is ignored; latched values are unchanged.
- RUN: win_ready = (issued < num) & ((fifo_count + inflight) < OUT_DEPTH).
  - `inflight` is the popcount of `vld_sr[LAT-1:0]`.
  - Each fire increments `issued`.
  - When the fire makes `issued` equal `num`, go to DRAIN next cycle.
- The valid shift register shifts every cycle, with bit 0 taking `fire`. When bit LAT-1 is set, `mac_out` is pushed into the FIFO at that cycle's end.
- The credit rule guarantees a push never hits a full FIFO. Push and pop in the same cycle are legal, including when full.
- res_last = head index (`popped`) equals num-1, while not in IDLE.
- DRAIN: when a pop occurs with `popped` = num-1, `done` pulses next cycle, `busy` drops with it, state returns to IDLE.
- Ordering: results are strictly in fire order. Bubbles (win_valid=0) insert zero windows whose results are discarded.
- `mac_exp_bias` holds its value after a job ends, until the next accepted start.

## Timing
- Reset values:
  - busy, done, win_ready, res_valid, res_last = 0.
  - mac_image, mac_weight, mac_exp_bias, res_data = 0.
  - vld_sr, FIFO pointers, counters = 0; state = IDLE.
- Asserting reset mid-job aborts it: all outputs go to reset values immediately, and no `done` is issued. Results still inside the MAC pipeline are ignored because `vld_sr` is cleared.
- Issue latency: `win_ready` can first be high in the cycle after the accepted `cfg_start`.
- Result latency: a fire in cycle t gives `res_valid` in cycle t+LAT+1 (pushed at the end of t+LAT) when the FIFO was empty.
- Throughput: one window per cycle sustained while `res_ready` = 1.
- Backpressure: with `res_ready` = 0, at most OUT_DEPTH windows are outstanding (FIFO plus in flight).
- `res_data` and `res_last` are stable while `res_valid` = 1 and `res_ready` = 0.

## Test plan
- num=4, win_valid=1, res_ready=1, start at cycle 0:
  - win_ready high in cycles 1–4; res_valid in cycles 7–10.
  - res_last in cycle 10; done in cycle 11; busy high in cycles 1–11.
- num=20, res_ready=0:
  - win_ready falls after the 8th fire and stays low.
  - Raise res_ready: all 20 results arrive in fire order, with no loss or duplication, and res_last on the 20th.
- num=0: done pulses one cycle after start; win_ready never asserts; FIFO stays empty.
- win_valid toggling 1,0,1,0 with num=3:
  - mac_image/mac_weight are 0 in bubble cycles.
  - The 3 results match the golden MAC outputs, in order.
- cfg_start during RUN with a different num and bias: ignored; mac_exp_bias and the window count are unchanged.
- rst pulsed low after 3 fires of num=10:
  - All outputs are 0 during reset.
  - A new num=2 job afterward yields exactly 2 correct results and one done.
